// File: rtl/dram_access_arbiter_if.sv
// Requester-side and memory-side signals of the shared 128-bit data-RAM port.
interface dram_access_arbiter_if;
    logic [31:0]  c_radr, u_radr;
    logic         c_rstart, u_rstart;
    logic [31:0]  c_wadr, u_wadr;
    logic [127:0] c_wdata, u_wdata;
    logic [15:0]  c_mask, u_mask;
    logic         c_wen, u_wen;
    logic         c_read_valid, u_read_valid;
    logic         c_wresp, u_wresp;
    logic         c_busy, u_busy;
    logic [127:0] rdata;
    logic [31:0]  m_radr;
    logic         m_rstart;
    logic [31:0]  m_wadr;
    logic [127:0] m_wdata;
    logic [15:0]  m_mask;
    logic         m_wen;
    logic [127:0] m_rdata;
    logic         m_read_valid;
    logic         m_wresp;

    modport slave (
        input  c_radr, c_rstart, c_wadr, c_wdata, c_mask, c_wen,
        input  u_radr, u_rstart, u_wadr, u_wdata, u_mask, u_wen,
        input  m_rdata, m_read_valid, m_wresp,
        output c_read_valid, c_wresp, c_busy,
        output u_read_valid, u_wresp, u_busy, rdata,
        output m_radr, m_rstart, m_wadr, m_wdata, m_mask, m_wen
    );

    modport master (
        output c_radr, c_rstart, c_wadr, c_wdata, c_mask, c_wen,
        output u_radr, u_rstart, u_wadr, u_wdata, u_mask, u_wen,
        output m_rdata, m_read_valid, m_wresp,
        input  c_read_valid, c_wresp, c_busy,
        input  u_read_valid, u_wresp, u_busy, rdata,
        input  m_radr, m_rstart, m_wadr, m_wdata, m_mask, m_wen
    );
endinterface

// File: rtl/dram_access_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between CPU (0) and UART (1).
module dram_access_arbiter #(
    parameter int unsigned TOUT = 255,
    parameter int unsigned TW   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dram_access_arbiter_if.slave  bus,
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  to_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;
    localparam logic [TW-1:0] TOUT_W = TW'(TOUT);

    state_e        state_q, state_d;
    logic          owner_q, rr_q;
    logic [TW-1:0] wd_q;
    logic          ovf_q, to_q;

    logic [1:0]    pend_q, pwr_q;
    logic [31:0]   padr_q [2];
    logic [127:0]  pdat_q [2];
    logic [15:0]   pmsk_q [2];

    logic [1:0]    wen_in, rd_in, pulse, req, issue, load, drop;
    logic [31:0]   adr_in [2];
    logic [127:0]  dat_in [2];
    logic [15:0]   msk_in [2];

    logic          grant, gsel, g_wr;
    logic [31:0]   g_adr;
    logic [127:0]  g_dat;
    logic [15:0]   g_msk;
    logic          tout, rd_done, wr_done, ovf_set, to_set;

    assign wen_in    = {bus.u_wen, bus.c_wen};
    assign rd_in     = {bus.u_rstart, bus.c_rstart};
    assign pulse     = wen_in | rd_in;
    assign adr_in[0] = bus.c_wen ? bus.c_wadr : bus.c_radr;
    assign adr_in[1] = bus.u_wen ? bus.u_wadr : bus.u_radr;
    assign dat_in[0] = bus.c_wdata;
    assign dat_in[1] = bus.u_wdata;
    assign msk_in[0] = bus.c_mask;
    assign msk_in[1] = bus.u_mask;

    // An incoming pulse bypasses an empty buffer so an idle grant costs no cycle.
    assign req = pend_q | pulse;

    always_comb begin
        gsel = req[1];
        if (&req) gsel = rr_q;
        grant = (state_q == IDLE) && (|req);
        issue = '0;
        if (grant) issue[gsel] = 1'b1;
        g_wr  = pend_q[gsel] ? pwr_q[gsel]  : wen_in[gsel];
        g_adr = pend_q[gsel] ? padr_q[gsel] : adr_in[gsel];
        g_dat = pend_q[gsel] ? pdat_q[gsel] : dat_in[gsel];
        g_msk = pend_q[gsel] ? pmsk_q[gsel] : msk_in[gsel];
    end

    // Load when empty and not bypassed, or when the held entry leaves now.
    assign load    = pulse & ~(pend_q ^ issue);
    assign drop    = pulse & pend_q & ~issue;
    assign ovf_set = rst_n && ((|drop) || (|(wen_in & rd_in)));

    assign tout    = (state_q != IDLE) && (wd_q == TOUT_W);
    assign rd_done = (state_q == RD_WAIT) && (bus.m_read_valid || tout);
    assign wr_done = (state_q == WR_WAIT) && (bus.m_wresp || tout);
    assign to_set  = rst_n && tout &&
                     !((state_q == RD_WAIT && bus.m_read_valid) ||
                       (state_q == WR_WAIT && bus.m_wresp));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = g_wr ? WR_WAIT : RD_WAIT;
            RD_WAIT: if (rd_done) state_d = IDLE;
            WR_WAIT: if (wr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.c_read_valid = rd_done && !owner_q;
        bus.u_read_valid = rd_done && owner_q;
        bus.c_wresp      = wr_done && !owner_q;
        bus.u_wresp      = wr_done && owner_q;
        bus.c_busy       = pend_q[0] || (state_q != IDLE && !owner_q);
        bus.u_busy       = pend_q[1] || (state_q != IDLE && owner_q);
        bus.rdata        = bus.m_rdata;
        ovf_err          = ovf_q || ovf_set;
        to_err           = to_q || to_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            wd_q         <= '0;
            ovf_q        <= 1'b0;
            to_q         <= 1'b0;
            bus.m_radr   <= '0;
            bus.m_rstart <= 1'b0;
            bus.m_wadr   <= '0;
            bus.m_wdata  <= '0;
            bus.m_mask   <= '0;
            bus.m_wen    <= 1'b0;
        end else begin
            bus.m_rstart <= 1'b0;
            bus.m_wen    <= 1'b0;
            wd_q         <= (state_q == IDLE) ? '0 : wd_q + 1'b1;
            if (grant) begin
                owner_q      <= gsel;
                rr_q         <= ~gsel;
                bus.m_rstart <= ~g_wr;
                bus.m_wen    <= g_wr;
                if (g_wr) begin
                    bus.m_wadr  <= {g_adr[31:4], 4'h0};
                    bus.m_wdata <= g_dat;
                    bus.m_mask  <= g_msk;
                end else begin
                    bus.m_radr  <= {g_adr[31:4], 4'h0};
                end
            end
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (to_set)       to_q  <= 1'b1;
            else if (err_clr) to_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            pwr_q  <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (load[x]) begin
                    pend_q[x] <= 1'b1;
                    pwr_q[x]  <= wen_in[x];
                    padr_q[x] <= adr_in[x];
                    pdat_q[x] <= dat_in[x];
                    pmsk_q[x] <= msk_in[x];
                end else if (issue[x]) begin
                    pend_q[x] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_access_arbiter.sv
// Scoreboard bench for dram_access_arbiter: expected memory-side issues are
// queued with the stimulus and popped as m_rstart/m_wen pulses appear.
module tb_dram_access_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic ovf_err, to_err;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit           wr;
        logic [31:0]  adr;
        logic [127:0] dat;
        logic [15:0]  msk;
    } txn_t;
    txn_t exp_q[$];
    txn_t mt;

    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
    localparam logic [127:0] DP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] RA = {16{8'hA5}};
    localparam logic [127:0] R5 = {16{8'h5A}};

    dram_access_arbiter_if bus();

    dram_access_arbiter #(.TOUT(8), .TW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .ovf_err (ovf_err),
        .to_err  (to_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    always @(negedge clk) begin
        if (rst_n && (bus.m_rstart || bus.m_wen)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got wen=%0b rstart=%0b want none",
                         bus.m_wen, bus.m_rstart);
            end else begin
                mt = exp_q.pop_front();
                if (mt.wr) begin
                    if (!(bus.m_wen && !bus.m_rstart && bus.m_wadr === mt.adr &&
                          bus.m_wdata === mt.dat && bus.m_mask === mt.msk)) begin
                        errors++;
                        $display("FAIL sb_write got wen=%0b adr=%h dat=%h msk=%h want adr=%h dat=%h msk=%h",
                                 bus.m_wen, bus.m_wadr, bus.m_wdata, bus.m_mask,
                                 mt.adr, mt.dat, mt.msk);
                    end
                end else begin
                    if (!(bus.m_rstart && !bus.m_wen && bus.m_radr === mt.adr)) begin
                        errors++;
                        $display("FAIL sb_read got rstart=%0b adr=%h want adr=%h",
                                 bus.m_rstart, bus.m_radr, mt.adr);
                    end
                end
            end
        end
    end

    function automatic void push(bit wr, logic [31:0] a, logic [127:0] d, logic [15:0] m);
        txn_t t;
        t.wr = wr; t.adr = a; t.dat = d; t.msk = m;
        exp_q.push_back(t);
    endfunction

    task automatic idle_in();
        bus.c_rstart = 0; bus.u_rstart = 0;
        bus.c_wen = 0; bus.u_wen = 0;
        bus.m_read_valid = 0; bus.m_wresp = 0;
        err_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        bus.c_radr = 0; bus.u_radr = 0; bus.c_wadr = 0; bus.u_wadr = 0;
        bus.c_wdata = 0; bus.u_wdata = 0; bus.c_mask = 0; bus.u_mask = 0;
        bus.m_rdata = 0;
        idle_in();
        do_reset();
        smp();
        checks++;
        if ({bus.m_rstart, bus.m_wen, bus.c_busy, bus.u_busy} !== 4'b0) begin
            errors++;
            $display("FAIL rst_ctrl got %b want 0000",
                     {bus.m_rstart, bus.m_wen, bus.c_busy, bus.u_busy});
        end
        checks++;
        if ({ovf_err, to_err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_err got %b want 00", {ovf_err, to_err});
        end
        checks++;
        if ({bus.m_radr, bus.m_wadr, bus.m_mask} !== 80'h0 || bus.m_wdata !== 128'h0) begin
            errors++;
            $display("FAIL rst_bus got radr=%h wadr=%h want 0", bus.m_radr, bus.m_wadr);
        end
    endtask

    task automatic test_single_read();
        cyc(); bus.u_rstart = 1; bus.u_radr = 32'h0000_1234;
        push(0, 32'h0000_1230, '0, '0);
        cyc(); smp();
        checks++;
        if (bus.m_rstart !== 1'b1 || bus.m_radr !== 32'h0000_1230) begin
            errors++;
            $display("FAIL rd_issue got rstart=%0b adr=%h want 1 00001230",
                     bus.m_rstart, bus.m_radr);
        end
        cyc(); smp();
        checks++;
        if (bus.m_rstart !== 1'b0 || bus.u_busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_pulse got rstart=%0b busy=%0b want 0 1",
                     bus.m_rstart, bus.u_busy);
        end
        cyc();
        cyc(); bus.m_read_valid = 1; bus.m_rdata = RA; smp();
        checks++;
        if ({bus.u_read_valid, bus.c_read_valid} !== 2'b10 || bus.rdata !== RA) begin
            errors++;
            $display("FAIL rd_resp got u=%0b c=%0b rdata=%h want 1 0 %h",
                     bus.u_read_valid, bus.c_read_valid, bus.rdata, RA);
        end
        cyc(); smp();
        checks++;
        if (bus.u_busy !== 1'b0 || bus.u_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_done got busy=%0b rv=%0b want 0 0",
                     bus.u_busy, bus.u_read_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.c_wen = 1; bus.c_wadr = 32'h0000_0107; bus.c_wdata = D1; bus.c_mask = 16'h0;
        bus.u_rstart = 1; bus.u_radr = 32'h0000_0200;
        push(1, 32'h0000_0100, D1, 16'h0);
        push(0, 32'h0000_0200, '0, '0);
        cyc(); smp();
        checks++;
        if ({bus.m_wen, bus.m_rstart, bus.c_busy, bus.u_busy} !== 4'b1011) begin
            errors++;
            $display("FAIL rr_first got %b want 1011",
                     {bus.m_wen, bus.m_rstart, bus.c_busy, bus.u_busy});
        end
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if ({bus.c_wresp, bus.u_wresp} !== 2'b10) begin
            errors++;
            $display("FAIL rr_wresp got %b want 10", {bus.c_wresp, bus.u_wresp});
        end
        cyc(); smp();
        checks++;
        if (bus.m_rstart !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap got %0b want 0", bus.m_rstart);
        end
        cyc(); bus.m_read_valid = 1; bus.m_rdata = R5; smp();
        checks++;
        if (bus.m_rstart !== 1'b1 || bus.u_read_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_second got rstart=%0b rv=%0b want 1 1",
                     bus.m_rstart, bus.u_read_valid);
        end
        cyc();
        cyc(); bus.c_rstart = 1; bus.c_radr = 32'h0000_0300;
        push(0, 32'h0000_0300, '0, '0);
        cyc(); bus.m_read_valid = 1;
        cyc();
        bus.c_wen = 1; bus.c_wadr = 32'h0000_0400;
        bus.u_wen = 1; bus.u_wadr = 32'h0000_0500; bus.u_wdata = D2; bus.u_mask = 16'h00f0;
        push(1, 32'h0000_0500, D2, 16'h00f0);
        push(1, 32'h0000_0400, D1, 16'h0);
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if (bus.m_wadr !== 32'h0000_0500 || bus.u_wresp !== 1'b1) begin
            errors++;
            $display("FAIL rr_uart_first got adr=%h uwr=%0b want 00000500 1",
                     bus.m_wadr, bus.u_wresp);
        end
        cyc();
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if (bus.m_wadr !== 32'h0000_0400 || bus.c_wresp !== 1'b1) begin
            errors++;
            $display("FAIL rr_cpu_next got adr=%h cwr=%0b want 00000400 1",
                     bus.m_wadr, bus.c_wresp);
        end
        cyc(); smp();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        cyc(); bus.c_rstart = 1; bus.c_radr = 32'h0000_0600;
        push(0, 32'h0000_0600, '0, '0);
        cyc(); bus.u_wen = 1; bus.u_wadr = 32'h0000_0700; bus.u_wdata = D2; bus.u_mask = 16'h00ff;
        push(1, 32'h0000_0700, D2, 16'h00ff);
        smp();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got %0b want 0", ovf_err);
        end
        cyc(); bus.u_wen = 1; bus.u_wadr = 32'h0000_0800; bus.u_wdata = D1; smp();
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got %0b want 1", ovf_err);
        end
        cyc(); smp();
        checks++;
        if (ovf_err !== 1'b1 || bus.u_busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%0b busy=%0b want 1 1", ovf_err, bus.u_busy);
        end
        cyc(); bus.m_read_valid = 1;
        cyc();
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if (bus.m_wen !== 1'b1 || bus.u_wresp !== 1'b1) begin
            errors++;
            $display("FAIL ovf_first_kept got wen=%0b wr=%0b want 1 1", bus.m_wen, bus.u_wresp);
        end
        cyc(); err_clr = 1;
        cyc(); smp();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got %0b want 0", ovf_err);
        end
        cyc();
        bus.c_wen = 1; bus.c_wadr = 32'h0000_0900; bus.c_wdata = D1; bus.c_mask = 16'h0;
        bus.c_rstart = 1; bus.c_radr = 32'h0000_0A00;
        push(1, 32'h0000_0900, D1, 16'h0);
        smp();
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_both got %0b want 1", ovf_err);
        end
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if ({bus.m_wen, bus.m_rstart} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_wr_only got %b want 10", {bus.m_wen, bus.m_rstart});
        end
        cyc(); err_clr = 1;
        bus.c_wen = 1; bus.c_wadr = 32'h0000_0B00; bus.c_rstart = 1;
        push(1, 32'h0000_0B00, D1, 16'h0);
        cyc(); bus.m_wresp = 1; smp();
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %0b want 1", ovf_err);
        end
        cyc(); smp();
        checks++;
        if (bus.m_rstart !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_no_read got rstart=%0b q=%0d want 0 0",
                     bus.m_rstart, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        cyc(); bus.c_rstart = 1; bus.c_radr = 32'h0000_0C00; bus.m_rdata = R5;
        push(0, 32'h0000_0C00, '0, '0);
        for (int k = 0; k < 8; k++) begin
            cyc(); smp();
            if (bus.c_read_valid !== 1'b0 || to_err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early got %0d want 0", early);
        end
        cyc(); smp();
        checks++;
        if ({bus.c_read_valid, to_err} !== 2'b11 || bus.rdata !== R5) begin
            errors++;
            $display("FAIL to_fire got rv=%0b to=%0b rdata=%h want 1 1 %h",
                     bus.c_read_valid, to_err, bus.rdata, R5);
        end
        cyc(); err_clr = 1; smp();
        checks++;
        if (to_err !== 1'b1 || bus.c_busy !== 1'b0 || bus.c_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_idle got to=%0b busy=%0b rv=%0b want 1 0 0",
                     to_err, bus.c_busy, bus.c_read_valid);
        end
        cyc(); smp();
        checks++;
        if (to_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clr got %0b want 0", to_err);
        end
    endtask

    task automatic test_mask();
        cyc(); bus.u_wen = 1; bus.u_wadr = 32'h0000_0D0C; bus.u_wdata = DP; bus.u_mask = 16'h0fff;
        push(1, 32'h0000_0D00, DP, 16'h0fff);
        cyc(); smp();
        checks++;
        if (bus.m_wen !== 1'b1 || bus.m_mask !== 16'h0fff || bus.m_wdata !== DP) begin
            errors++;
            $display("FAIL mask_pass got wen=%0b msk=%h dat=%h want 1 0fff %h",
                     bus.m_wen, bus.m_mask, bus.m_wdata, DP);
        end
        cyc(); smp();
        checks++;
        if (bus.m_wen !== 1'b0 || bus.m_mask !== 16'h0fff) begin
            errors++;
            $display("FAIL mask_pulse got wen=%0b msk=%h want 0 0fff", bus.m_wen, bus.m_mask);
        end
        cyc(); bus.m_wresp = 1;
        cyc();
    endtask

    task automatic test_reset_mid();
        cyc(); bus.c_wen = 1; bus.c_wadr = 32'h0000_0E00; bus.c_wdata = D2; bus.c_mask = 16'h1;
        push(1, 32'h0000_0E00, D2, 16'h1);
        cyc();
        cyc(); rst_n = 0;
        cyc(); rst_n = 1; bus.m_wresp = 1; smp();
        checks++;
        if ({bus.m_wen, bus.m_rstart, bus.c_busy, bus.u_busy, bus.c_wresp, bus.u_wresp} !== 6'b0) begin
            errors++;
            $display("FAIL mid_rst_ctrl got %b want 000000",
                     {bus.m_wen, bus.m_rstart, bus.c_busy, bus.u_busy, bus.c_wresp, bus.u_wresp});
        end
        checks++;
        if (bus.m_wadr !== 32'h0 || bus.m_wdata !== 128'h0 || bus.m_mask !== 16'h0) begin
            errors++;
            $display("FAIL mid_rst_bus got adr=%h msk=%h want 0 0", bus.m_wadr, bus.m_mask);
        end
        cyc(); smp();
        checks++;
        if (exp_q.size() != 0 || bus.c_wresp !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_end got q=%0d wr=%0b want 0 0", exp_q.size(), bus.c_wresp);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_overflow();
        test_timeout();
        test_mask();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
